// File: rtl/vga_raster_if.sv
// vga_raster_if: raster coordinates out, final pixel colour back, VGA pins out
interface vga_raster_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic [7:0]  RGBin;
  logic [3:0]  vgaR;
  logic [3:0]  vgaG;
  logic [3:0]  vgaB;
  logic        hsync;
  logic        vsync;
  logic        blankN;
  modport master (output pixelX, pixelY, startOfFrame, vgaR, vgaG, vgaB, hsync, vsync, blankN,
                  input RGBin);
  modport slave  (input pixelX, pixelY, startOfFrame, vgaR, vgaG, vgaB, hsync, vsync, blankN,
                  output RGBin);
endinterface

// File: rtl/vga_raster_gen.sv
// vga_raster_gen: raster counters, delayed sync/blank and 4-4-4 DAC stage (VGA_BORDER_EN adds a white border)
module vga_raster_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1,
  parameter bit SYNC_ACT   = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  vga_raster_if.master  vif
);
  localparam logic [10:0] X_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] Y_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] HA1    = 11'(H_ACTIVE - 1);
  localparam logic [10:0] HS0    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] VA1    = 11'(V_ACTIVE - 1);
  localparam logic [10:0] VS0    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1    = 11'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_BORDER_EN
  localparam int TW = 4;
`else
  localparam int TW = 3;
`endif
  logic [10:0]   x_q, x_d, y_q, y_d;
  logic          sof_q, sof_d;
  logic          act_r, hs_r, vs_r, brd;
  logic [TW-1:0] raw, dly;
  logic          blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
  logic [3:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  // counters wrap only at the end of line / end of frame; SOF flags the (0,0) pixel
  always_comb begin
    x_d   = x_q == X_LAST ? 11'd0 : x_q + 11'd1;
    y_d   = x_q != X_LAST ? y_q : (y_q == Y_LAST ? 11'd0 : y_q + 11'd1);
    sof_d = x_d == 11'd0 && y_d == 11'd0;
  end
  // raw timing decode of the current coordinates
  always_comb begin
    act_r = x_q < HA && y_q < VA;
    hs_r  = x_q >= HS0 && x_q < HS1;
    vs_r  = y_q >= VS0 && y_q < VS1;
  end
`ifdef VGA_BORDER_EN
  assign raw = {act_r, hs_r, vs_r, x_q == 11'd0 || x_q == HA1 || y_q == 11'd0 || y_q == VA1};
  assign brd = dly[0];
`else
  assign raw = {act_r, hs_r, vs_r};
  assign brd = 1'b0;
`endif
  if (PIPE_DELAY == 0) begin : g_nodly
    assign dly = raw;
  end else begin : g_dly
    logic [PIPE_DELAY*TW-1:0] sh_q, sh_d;
    // shift the timing tuple to match the object/mux latency of RGBin
    always_comb sh_d = (PIPE_DELAY*TW)'({sh_q, raw});
    // delay line clears to inactive on reset
    always_ff @(posedge clk)
      if (reset) sh_q <= '0;
      else sh_q <= sh_d;
    assign dly = sh_q[PIPE_DELAY*TW-1 -: TW];
  end
  // output stage: sync polarity, blanking and RRRGGGBB -> 4-4-4 bit replication
  always_comb begin
    blank_d = dly[TW-1];
    hs_d    = dly[TW-2] ? SYNC_ACT : !SYNC_ACT;
    vs_d    = dly[TW-3] ? SYNC_ACT : !SYNC_ACT;
    r_d     = !dly[TW-1] ? 4'h0 : brd ? 4'hF : {vif.RGBin[7:5], vif.RGBin[7]};
    g_d     = !dly[TW-1] ? 4'h0 : brd ? 4'hF : {vif.RGBin[4:2], vif.RGBin[4]};
    b_d     = !dly[TW-1] ? 4'h0 : brd ? 4'hF : {vif.RGBin[1:0], vif.RGBin[1:0]};
  end
  // all outputs registered; reset parks counters on the last pixel so release starts at (0,0)
  always_ff @(posedge clk)
    if (reset) begin
      x_q     <= X_LAST;
      y_q     <= Y_LAST;
      sof_q   <= 1'b0;
      blank_q <= 1'b0;
      hs_q    <= !SYNC_ACT;
      vs_q    <= !SYNC_ACT;
      r_q     <= 4'h0;
      g_q     <= 4'h0;
      b_q     <= 4'h0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      sof_q   <= sof_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  assign vif.pixelX       = x_q;
  assign vif.pixelY       = y_q;
  assign vif.startOfFrame = sof_q;
  assign vif.blankN       = blank_q;
  assign vif.hsync        = hs_q;
  assign vif.vsync        = vs_q;
  assign vif.vgaR         = r_q;
  assign vif.vgaG         = g_q;
  assign vif.vgaB         = b_q;
endmodule
